tick_meter: RTL and testbench
=============================

TICK_METER -- requirements
Module: tick_meter

Interface
REQ-001 SHALL have parameter WINDOW, default 50000000, the measurement window length in iCLK cycles, legal range 2..2^32-1.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the edge count.
REQ-003 SHALL have port iCLK, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port iRST, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port iTICK, input, 1 bit: the monitored clock/tick signal, asynchronous to iCLK.
REQ-006 SHALL have port iENABLE, input, 1 bit: level; high runs measurement, low idles.
REQ-007 SHALL have port oCOUNT, output, CNT_W bits: the rising-edge count of the last completed window.
REQ-008 SHALL have port oOVF, output, 1 bit: the last completed window saturated.
REQ-009 SHALL have port oVALID, output, 1 bit: a one-cycle pulse when oCOUNT/oOVF update.
REQ-010 SHALL have port oPERIOD, output, 32 bits: iCLK cycles between the last two detected edges.

Function
REQ-011 SHALL synchronise iTICK through two flops (s1, s2), then a third flop s3; edge = s2 & ~s3.
REQ-012 SHALL make edge high in exactly the 3rd iCLK rising edge after iTICK is first sampled high; one edge per iTICK low->high transition, pulses shorter than one iCLK period may be missed.
REQ-013 SHALL implement states IDLE and COUNT only; the state encoding is free.
REQ-014 SHALL, in IDLE, hold the window counter and edge counter at 0; iENABLE=1 SHALL move to COUNT on the next cycle.
REQ-015 SHALL, in COUNT, increment the window counter every cycle from 0; an edge in a cycle SHALL increment the edge counter.
REQ-016 SHALL saturate the edge counter at 2^CNT_W-1; an edge while saturated SHALL set a window-local overflow flag.
REQ-017 SHALL, when the window counter == WINDOW-1, include any edge occurring in that same cycle in the total.
REQ-018 SHALL, on that cycle, register the saturated total into oCOUNT and the overflow flag into oOVF, and assert oVALID on the next cycle for exactly one cycle.
REQ-019 SHALL, at the end of a window, clear the window counter, edge counter and flag, then remain in COUNT if iENABLE=1 (back-to-back windows, no gap cycle), else go to IDLE.
REQ-020 SHALL, if iENABLE falls mid-window, go to IDLE next cycle, discard the partial counts, hold oCOUNT/oOVF, and produce no oVALID.
REQ-021 SHALL hold oCOUNT and oOVF constant between oVALID pulses.
REQ-022 SHALL leave the synchroniser running in IDLE, so an iTICK level held across an enable does not create a spurious edge.

Reset
REQ-023 SHALL, on iRST=1, immediately (without iCLK) clear s1..s3, both counters, the flag, oCOUNT, oOVF, oVALID and oPERIOD to 0, with state=IDLE.
REQ-024 SHALL, on iRST asserted mid-window, discard the window; the first window after release SHALL start when iENABLE is seen high.

Configuration
REQ-025 SHALL, with macro TICK_METER_PERIOD_EN defined, run a 32-bit period counter: it increments each cycle and saturates at 32'hFFFFFFFF.
REQ-026 SHALL, on each edge, load the period counter value +1 into oPERIOD (skipped for the first edge after reset or IDLE) and restart the counter at 0.
REQ-027 SHALL, in IDLE, clear the period counter and re-arm the first-edge skip; oPERIOD SHALL hold its value.
REQ-028 SHALL, with TICK_METER_PERIOD_EN undefined, tie oPERIOD to 0 and add no period logic; all other behaviour SHALL be identical.

Verification (bench WINDOW=16, CNT_W=4)
REQ-029 SHALL test: iTICK toggled every 2 iCLK (period 4) with iENABLE=1 from reset -> oVALID every 16 cycles, oCOUNT=4, oOVF=0; oPERIOD=4 with the macro defined.
REQ-030 SHALL test: iTICK = iCLK/2 (period 2 cycles) -> 8 edges per window, oCOUNT=8; then period 1-cycle-high/1-low repeated every 2 -> oCOUNT=8, no overflow; CNT_W=3 variant -> oCOUNT=7, oOVF=1.
REQ-031 SHALL test: an edge in the cycle the window counter==15 -> counted in that window, not the next.
REQ-032 SHALL test: iENABLE dropped at window cycle 9 -> no oVALID, oCOUNT keeps the previous value; re-enable -> the next oVALID comes 16 cycles after entering COUNT.
REQ-033 SHALL test: iRST pulsed asynchronously (between iCLK edges) mid-window -> all outputs read 0 before the next iCLK edge.
REQ-034 SHALL test: iTICK held high across the iENABLE rise -> oCOUNT=0, oPERIOD unchanged.

Source files
------------

// File: rtl/tick_meter.sv
// tick_meter: counts rising edges of an asynchronous tick over a fixed window of iCLK cycles.
// Defining TICK_METER_PERIOD_EN adds a measurement of the iCLK cycles between consecutive edges.
module tick_meter #(
  parameter int unsigned WINDOW = 32'd50000000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iTICK,
  input  logic             iENABLE,
  output logic [CNT_W-1:0] oCOUNT,
  output logic             oOVF,
  output logic             oVALID,
  output logic [31:0]      oPERIOD
);

  localparam logic             ST_IDLE  = 1'b0;
  localparam logic             ST_COUNT = 1'b1;
  localparam logic [31:0]      WIN_LAST = 32'(WINDOW - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic             state_q, state_d;
  logic [31:0]      win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             win_ovf_q, win_ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic tick_edge;
  logic win_end;
  logic edge_sat;

  assign tick_edge = s2_q & ~s3_q;
  assign win_end   = (win_cnt_q == WIN_LAST);
  assign edge_sat  = (edge_cnt_q == CNT_MAX);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    s1_d       = iTICK;
    s2_d       = s1_q;
    s3_d       = s2_q;
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    win_ovf_d  = win_ovf_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        win_ovf_d  = 1'b0;
        if (iENABLE) state_d = ST_COUNT;
      end
      default: begin
        if (tick_edge && !edge_sat) edge_cnt_d = edge_cnt_q + 1'b1;
        win_ovf_d = win_ovf_q | (tick_edge & edge_sat);

        if (win_end) begin
          // The final cycle's edge is already folded into edge_cnt_d/win_ovf_d.
          count_d    = edge_cnt_d;
          ovf_d      = win_ovf_d;
          valid_d    = 1'b1;
          win_cnt_d  = '0;
          edge_cnt_d = '0;
          win_ovf_d  = 1'b0;
          state_d    = iENABLE ? ST_COUNT : ST_IDLE;
        end else if (!iENABLE) begin
          win_cnt_d  = '0;
          edge_cnt_d = '0;
          win_ovf_d  = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          win_cnt_d = win_cnt_q + 32'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= ST_IDLE;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      win_ovf_q  <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      state_q    <= state_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      win_ovf_q  <= win_ovf_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign oCOUNT = count_q;
  assign oOVF   = ovf_q;
  assign oVALID = valid_q;

`ifdef TICK_METER_PERIOD_EN
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [31:0] period_q, period_d;
  logic        skip_q, skip_d;

  // skip_q marks that no reference edge exists yet in this COUNT run.
  always_comb begin
    per_cnt_d = per_cnt_q;
    period_d  = period_q;
    skip_d    = skip_q;
    if (state_q == ST_IDLE) begin
      per_cnt_d = '0;
      skip_d    = 1'b1;
    end else if (tick_edge) begin
      if (!skip_q) period_d = (per_cnt_q == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : per_cnt_q + 32'd1;
      skip_d    = 1'b0;
      per_cnt_d = '0;
    end else if (per_cnt_q != 32'hFFFF_FFFF) begin
      per_cnt_d = per_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      per_cnt_q <= '0;
      period_q  <= '0;
      skip_q    <= 1'b1;
    end else begin
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      skip_q    <= skip_d;
    end
  end

  assign oPERIOD = period_q;
`else
  assign oPERIOD = '0;
`endif

endmodule

// File: tb/tb_tick_meter.sv
// tb_tick_meter: two tick_meter instances (CNT_W=4 and CNT_W=3, WINDOW=16) against a window/edge model.
`timescale 1ns/1ps
module tb_tick_meter;

  localparam int unsigned W = 16;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iTICK;
  logic        iENABLE = 1'b0;
  logic [3:0]  count4;
  logic        ovf4, valid4;
  logic [31:0] period4;
  logic [2:0]  count3;
  logic        ovf3, valid3;
  logic [31:0] period3;

  always #5 iCLK = ~iCLK;

  tick_meter #(.WINDOW(W), .CNT_W(4)) dut4 (
    .iCLK(iCLK), .iRST(iRST), .iTICK(iTICK), .iENABLE(iENABLE),
    .oCOUNT(count4), .oOVF(ovf4), .oVALID(valid4), .oPERIOD(period4)
  );

  tick_meter #(.WINDOW(W), .CNT_W(3)) dut3 (
    .iCLK(iCLK), .iRST(iRST), .iTICK(iTICK), .iENABLE(iENABLE),
    .oCOUNT(count3), .oOVF(ovf3), .oVALID(valid3), .oPERIOD(period3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_per(input int p);
`ifdef TICK_METER_PERIOD_EN
    return 32'(p);
`else
    return 32'd0 + 32'(p * 0);
`endif
  endfunction

  // ---------------- behavioural model ----------------
  // An edge is counted at the clock edge two after the one that first sees iTICK high.
  bit          hist[3] = '{0, 0, 0};
  bit          running = 0, have_last = 0, ev;
  int          win_pos = 0, edges = 0;
  longint      cyc = 0, last_edge = 0, diff;
  int          exp_cnt4 = 0, exp_cnt3 = 0;
  bit          exp_ovf4 = 0, exp_ovf3 = 0, exp_valid = 0;
  logic [31:0] exp_period = '0;

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hist = '{0, 0, 0};
      running = 0; have_last = 0; win_pos = 0; edges = 0;
      exp_cnt4 = 0; exp_cnt3 = 0; exp_ovf4 = 0; exp_ovf3 = 0;
      exp_valid = 0; exp_period = '0;
    end else begin
      cyc++;
      ev = hist[1] && !hist[2];
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = iTICK;
      exp_valid = 0;
      if (!running) begin
        have_last = 0;
        if (iENABLE) begin running = 1; win_pos = 0; edges = 0; end
      end else begin
        if (ev) begin
          if (have_last) begin
            diff = cyc - last_edge;
            exp_period = (diff > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : diff[31:0];
          end
          have_last = 1;
          last_edge = cyc;
          edges++;
        end
        if (win_pos == int'(W) - 1) begin
          exp_cnt4 = (edges > 15) ? 15 : edges;
          exp_ovf4 = edges > 15;
          exp_cnt3 = (edges > 7) ? 7 : edges;
          exp_ovf3 = edges > 7;
          exp_valid = 1;
          win_pos = 0; edges = 0;
          running = iENABLE;
        end else if (!iENABLE) begin
          running = 0;
        end else begin
          win_pos++;
        end
      end
    end
  end

  always @(negedge iCLK) begin
    check("count4", 64'(count4), 64'(exp_cnt4));
    check("ovf4",   64'(ovf4),   64'(exp_ovf4));
    check("valid4", 64'(valid4), 64'(exp_valid));
    check("count3", 64'(count3), 64'(exp_cnt3));
    check("ovf3",   64'(ovf3),   64'(exp_ovf3));
    check("valid3", 64'(valid3), 64'(exp_valid));
`ifdef TICK_METER_PERIOD_EN
    check("period4", 64'(period4), 64'(exp_period));
    check("period3", 64'(period3), 64'(exp_period));
`else
    check("period4", 64'(period4), 64'd0);
    check("period3", 64'(period3), 64'd0);
`endif
  end

  // ---------------- tick generator ----------------
  int   tick_period = 0, tick_high = 0;
  logic tick_level = 1'b0;

  initial begin
    int ph = 0;
    iTICK = 1'b0;
    forever begin
      @(posedge iCLK);
      #2;
      if (tick_period > 0) begin
        iTICK = (ph < tick_high);
        ph = (ph + 1) % tick_period;
      end else begin
        iTICK = tick_level;
        ph = 0;
      end
    end
  end

  task automatic wait_valid(input string name, output int n);
    n = 0;
    do begin
      @(negedge iCLK);
      n++;
    end while (!valid4 && n < 40);
    check({name, "_seen"}, 64'(valid4), 64'd1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_count4"}, 64'(count4), 64'd0);
    check({name, "_ovf4"},   64'(ovf4),   64'd0);
    check({name, "_valid4"}, 64'(valid4), 64'd0);
    check({name, "_per4"},   64'(period4), 64'd0);
    check({name, "_count3"}, 64'(count3), 64'd0);
    check({name, "_ovf3"},   64'(ovf3),   64'd0);
    check({name, "_per3"},   64'(period3), 64'd0);
  endtask

  initial begin
    int n, vcnt;
    #1 iRST = 1'b1;
    #1 check_zero("reset");
    repeat (3) @(negedge iCLK);
    #1;
    iRST = 1'b0;
    tick_period = 4; tick_high = 2;
    iENABLE = 1'b1;

    // period-4 tick: 4 edges every 16-cycle window
    wait_valid("p4_w1", n);
    wait_valid("p4_w2", n);
    check("p4_spacing", 64'(n), 64'd16);
    wait_valid("p4_w3", n);
    check("p4_spacing2", 64'(n), 64'd16);
    check("p4_count4", 64'(count4), 64'd4);
    check("p4_ovf4",   64'(ovf4),   64'd0);
    check("p4_count3", 64'(count3), 64'd4);
    check("p4_period", 64'(period4), 64'(exp_per(4)));

    // period-2 tick: 8 edges, saturates the 3-bit counter
    tick_period = 2; tick_high = 1;
    wait_valid("p2_w1", n);
    wait_valid("p2_w2", n);
    check("p2_count4", 64'(count4), 64'd8);
    check("p2_ovf4",   64'(ovf4),   64'd0);
    check("p2_count3", 64'(count3), 64'd7);
    check("p2_ovf3",   64'(ovf3),   64'd1);
    check("p2_period", 64'(period4), 64'(exp_per(2)));

    // single edge landing in window cycle 15
    tick_period = 0; tick_level = 1'b0;
    wait_valid("quiet_w1", n);
    wait_valid("quiet_w2", n);
    check("quiet_count4", 64'(count4), 64'd0);
    repeat (12) @(negedge iCLK);
    tick_level = 1'b1;
    wait_valid("last_cyc", n);
    check("last_cyc_delay", 64'(n), 64'd4);
    check("last_cyc_count", 64'(count4), 64'd1);
    wait_valid("after_last", n);
    check("after_last_count", 64'(count4), 64'd0);

    // enable dropped at window cycle 9, then re-enabled
    tick_period = 4; tick_high = 2;
    wait_valid("pre_drop_w1", n);
    wait_valid("pre_drop_w2", n);
    check("pre_drop_count", 64'(count4), 64'd4);
    repeat (9) @(negedge iCLK);
    iENABLE = 1'b0;
    vcnt = 0;
    repeat (30) begin
      @(negedge iCLK);
      if (valid4) vcnt++;
    end
    check("drop_no_valid", 64'(vcnt), 64'd0);
    check("drop_hold_count", 64'(count4), 64'd4);
    iENABLE = 1'b1;
    @(posedge iCLK);
    n = 0;
    do begin
      @(posedge iCLK);
      n++;
      @(negedge iCLK);
    end while (!valid4 && n < 40);
    check("reenable_latency", 64'(n), 64'd16);
    check("reenable_count", 64'(count4), 64'd4);

    // asynchronous reset mid-window
    repeat (5) @(negedge iCLK);
    @(posedge iCLK);
    #3 iRST = 1'b1;
    #1 check_zero("async_rst");
    @(negedge iCLK);
    #1 iRST = 1'b0;
    wait_valid("post_rst_w1", n);
    wait_valid("post_rst_w2", n);
    check("post_rst_count", 64'(count4), 64'd4);
    check("post_rst_period", 64'(period4), 64'(exp_per(4)));

    // iTICK held high across the enable rise
    iENABLE = 1'b0;
    repeat (3) @(negedge iCLK);
    tick_period = 0; tick_level = 1'b1;
    repeat (6) @(negedge iCLK);
    iENABLE = 1'b1;
    wait_valid("held_w1", n);
    check("held_count4", 64'(count4), 64'd0);
    check("held_ovf4",   64'(ovf4),   64'd0);
    check("held_count3", 64'(count3), 64'd0);
    check("held_period", 64'(period4), 64'(exp_per(4)));
    wait_valid("held_w2", n);
    check("held_count4_w2", 64'(count4), 64'd0);

    repeat (2) @(negedge iCLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
